// File: rtl/mc_pkg.sv
// Shared types for the multicycle MIPS control FSM: state encoding, opcodes, ALU/mux codes.
// Pure declarations, no timing or backpressure of its own.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_4       = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    // Immediate-class ALU setup as {ext_op, alu_op}; logical immediates zero-extend.
    function automatic logic [3:0] imm_ctrl(input logic [5:0] op);
        case (op)
            OP_ANDI: imm_ctrl = {1'b1, ALU_AND};
            OP_ORI:  imm_ctrl = {1'b1, ALU_OR};
            default: imm_ctrl = {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state + registered opcode -> datapath control word; zero latency.
// No handshake of its own; every control not named for a state stays 0.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_e      state,
    input  logic [5:0]  op_q,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (op_q == OP_BNE);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_IEXEC: begin
                ctrl.alu_src_a                 = 1'b1;
                ctrl.alu_src_b                 = SRCB_IMM;
                {ctrl.ext_op, ctrl.alu_op}     = imm_ctrl(op_q);
            end
            // ALU setup is held through write-back so ALUOut stays consistent.
            S_IWB: begin
                ctrl.reg_write                 = 1'b1;
                {ctrl.ext_op, ctrl.alu_op}     = imm_ctrl(op_q);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM; Moore outputs, 3-5 cycles per instruction. Optional MC_MEM_WAIT_EN:
// FETCH/MEMRD/MEMWR stall on mem_ready=0 (PC written only on the ready cycle); otherwise mem_ready is ignored.
module multicycle_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [1:0] PCSource,
    output logic [2:0] ALUop,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       illegal_d;
    logic       mem_ok;
    ctrl_t      ctrl_raw, ctrl_o;

`ifdef MC_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: if (mem_ok) state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_R:                     state_d = S_REXEC;
                    OP_BEQ, OP_BNE:           state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ok) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ok) state_d = S_FETCH;
            S_REXEC:  state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    mc_output_decode u_decode (
        .state (state_q),
        .op_q  (op_q),
        .ctrl  (ctrl_raw)
    );

    // Reset gates the architectural write strobes combinationally so an abort never commits.
    always_comb begin
        ctrl_o = ctrl_raw;
`ifdef MC_MEM_WAIT_EN
        if (state_q == S_FETCH && !mem_ready) ctrl_o.pc_write = 1'b0;
`endif
        if (rst) begin
            ctrl_o.pc_write      = 1'b0;
            ctrl_o.pc_write_cond = 1'b0;
            ctrl_o.ir_write      = 1'b0;
            ctrl_o.mem_write     = 1'b0;
            ctrl_o.reg_write     = 1'b0;
        end
    end

    assign PCWrite     = ctrl_o.pc_write;
    assign PCWriteCond = ctrl_o.pc_write_cond;
    assign BranchNe    = ctrl_o.branch_ne;
    assign IorD        = ctrl_o.i_or_d;
    assign MemRead     = ctrl_o.mem_read;
    assign MemWrite    = ctrl_o.mem_write;
    assign IRWrite     = ctrl_o.ir_write;
    assign MemtoReg    = ctrl_o.mem_to_reg;
    assign RegDst      = ctrl_o.reg_dst;
    assign RegWrite    = ctrl_o.reg_write;
    assign ALUSrcA     = ctrl_o.alu_src_a;
    assign ALUSrcB     = ctrl_o.alu_src_b;
    assign ExtOp       = ctrl_o.ext_op;
    assign PCSource    = ctrl_o.pc_source;
    assign ALUop       = ctrl_o.alu_op;
    assign illegal_op  = illegal_d & ~rst;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output traces compared every cycle,
// plus literal checks of the directed test-plan cases; randomized opcodes, resets and mem_ready.
module tb_multicycle_control;

`ifdef MC_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp, illegal_op;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUop;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .PCSource(PCSource),
        .ALUop(ALUop), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb;
        logic       ext;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       ill;
    } obs_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] want;
    } lit_t;

    obs_t dut_obs;
    assign dut_obs = {state, PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                      MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtOp, PCSource, ALUop, illegal_op};

    obs_t exp_q[$];
    obs_t hist[$];
    obs_t trace[$];
    lit_t lit_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [5:0] ops[9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                           6'b001000, 6'b001100, 6'b001101, 6'b000010};

    function automatic obs_t mk(input logic [3:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    // Expected cycle-by-cycle outputs of one whole instruction, straight from the state table.
    function automatic void build(input logic [5:0] op);
        obs_t o;
        trace.delete();
        o = mk(0); o.mrd = 1; o.irw = 1; o.pcw = 1; o.srcb = 2'b01;
        trace.push_back(o);
        o = mk(1); o.srcb = 2'b11;
        o.ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                             6'b001000, 6'b001100, 6'b001101, 6'b000010});
        trace.push_back(o);
        case (op)
            6'b100011, 6'b101011: begin
                o = mk(2); o.srca = 1; o.srcb = 2'b10; trace.push_back(o);
                if (op == 6'b100011) begin
                    o = mk(3); o.mrd = 1; o.iord = 1; trace.push_back(o);
                    o = mk(4); o.rw = 1; o.m2r = 1; trace.push_back(o);
                end else begin
                    o = mk(5); o.mwr = 1; o.iord = 1; trace.push_back(o);
                end
            end
            6'b000000: begin
                o = mk(6); o.srca = 1; o.aluop = 3'b010; trace.push_back(o);
                o = mk(7); o.rw = 1; o.rdst = 1; trace.push_back(o);
            end
            6'b000100, 6'b000101: begin
                o = mk(8); o.srca = 1; o.aluop = 3'b001; o.pcwc = 1; o.pcsrc = 2'b01;
                o.bne = (op == 6'b000101);
                trace.push_back(o);
            end
            6'b000010: begin
                o = mk(9); o.pcw = 1; o.pcsrc = 2'b10; trace.push_back(o);
            end
            6'b001000, 6'b001100, 6'b001101: begin
                o = mk(10); o.srca = 1; o.srcb = 2'b10;
                o.aluop = (op == 6'b001100) ? 3'b100 : (op == 6'b001101) ? 3'b011 : 3'b000;
                o.ext   = (op != 6'b001000);
                trace.push_back(o);
                o.st = 4'd11; o.srca = 0; o.srcb = 2'b00; o.rw = 1;
                trace.push_back(o);
            end
            default: ;
        endcase
    endfunction

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        lit_t l;
        l.name = name; l.got = got; l.want = want;
        lit_q.push_back(l);
    endtask

    function automatic logic [31:0] states();
        logic [31:0] s;
        s = '0;
        foreach (hist[k]) s = {s[27:0], hist[k].st};
        return s;
    endfunction

    function automatic int count_rw();
        int c;
        c = 0;
        foreach (hist[k]) c += int'(hist[k].rw);
        return c;
    endfunction

    function automatic int count_ill();
        int c;
        c = 0;
        foreach (hist[k]) c += int'(hist[k].ill);
        return c;
    endfunction

    task automatic do_reset(input int n);
        obs_t r;
        r = '0; r.mrd = 1; r.srcb = 2'b01;
        repeat (n) begin
            @(negedge clk);
            rst = 1'b1; opcode = 6'($urandom); mem_ready = 1'($urandom);
            exp_q.push_back(r);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input bit rand_rdy, input bit allow_abort);
        int   i, abort_at;
        obs_t e;
        logic rdy;
        build(op);
        abort_at = -1;
        if (allow_abort && $urandom_range(0, 7) == 0) abort_at = $urandom_range(0, trace.size() - 1);
        i = 0;
        while (i < trace.size()) begin
            if (i == abort_at) begin
                do_reset($urandom_range(1, 2));
                return;
            end
            e   = trace[i];
            rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            rst = 1'b0; mem_ready = rdy;
            opcode = (i == 1) ? op : 6'($urandom);
            if (WAIT_EN && !rdy && (e.st == 4'd0 || e.st == 4'd3 || e.st == 4'd5)) begin
                e.pcw = 1'b0;
                exp_q.push_back(e);
            end else begin
                exp_q.push_back(e);
                i++;
            end
        end
    endtask

    initial begin : compare
        obs_t e;
        lit_t l;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                hist.push_back(dut_obs);
                n_tests++;
                if (dut_obs !== e) begin
                    n_fail++;
                    $display("FAIL trace t=%0t state=%0d got=%h want=%h", $time, dut_obs.st, dut_obs, e);
                end
            end
            while (lit_q.size() != 0) begin
                l = lit_q.pop_front();
                n_tests++;
                if (l.got !== l.want) begin
                    n_fail++;
                    $display("FAIL %s got=%0h want=%0h", l.name, l.got, l.want);
                end
            end
        end
    end

    initial begin : drive
        logic [5:0] op;
        do_reset(2);
        #3;
        lit("rst_state", 32'(hist[$].st), 0);
        lit("rst_pcwrite", 32'(hist[$].pcw), 0);
        lit("rst_memread", 32'(hist[$].mrd), 1);
        hist.delete();

        run_instr(6'b100011, 1'b0, 1'b0); #3;
        lit("lw_states", states(), 32'h01234);
        lit("lw_memrd_read", 32'(hist[3].mrd), 1);
        lit("lw_regwrite_once", 32'(count_rw()), 1);
        lit("lw_memwb", 32'({hist[4].rw, hist[4].m2r, hist[4].rdst}), 32'b110);
        hist.delete();

        run_instr(6'b000000, 1'b0, 1'b0); #3;
        lit("r_states", states(), 32'h0167);
        lit("r_aluop", 32'(hist[2].aluop), 2);
        lit("r_rwb", 32'({hist[3].rw, hist[3].rdst}), 32'b11);
        hist.delete();

        run_instr(6'b000101, 1'b0, 1'b0); #3;
        lit("bne_states", states(), 32'h018);
        lit("bne_branch", 32'({hist[2].aluop, hist[2].pcwc, hist[2].bne, hist[2].pcsrc}), 32'h1D);
        hist.delete();

        run_instr(6'b001101, 1'b0, 1'b0); #3;
        lit("ori_iexec", 32'({hist[2].aluop, hist[2].ext}), 32'b0111);
        lit("ori_iwb", 32'({hist[3].rw, hist[3].aluop}), 32'b1011);
        hist.delete();

        run_instr(6'b001100, 1'b0, 1'b0); #3;
        lit("andi_iexec", 32'({hist[2].aluop, hist[2].ext}), 32'b1001);
        hist.delete();

        run_instr(6'b111111, 1'b0, 1'b0); #3;
        lit("ill_states", states(), 32'h01);
        lit("ill_pulses", 32'(count_ill()), 1);
        hist.delete();

        // Reset asserted in the middle of a MEMWR cycle must kill the store at once.
        build(6'b101011);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst = 1'b0; mem_ready = 1'b1;
            opcode = (i == 1) ? 6'b101011 : 6'($urandom);
            exp_q.push_back(trace[i]);
        end
        #3;
        lit("memwr_before", 32'(MemWrite), 1);
        rst = 1'b1;
        #1;
        lit("memwr_rst_memwrite", 32'(MemWrite), 0);
        lit("memwr_rst_state", 32'(state), 0);
        do_reset(1);

        if (WAIT_EN) begin
            hist.delete();
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                rst = 1'b0; mem_ready = 1'b0; opcode = 6'($urandom);
                exp_q.push_back(mk(0) | obs_t'({4'd0, 11'b00001010000, 2'b01, 1'b0, 2'b00, 3'b000, 1'b0}));
                #3;
                lit("wait_state", 32'(state), 0);
                lit("wait_pcwrite", 32'(PCWrite), 0);
            end
            run_instr(6'b000010, 1'b0, 1'b0); #3;
            lit("wait_ready_pcwrite", 32'(hist[3].pcw), 1);
            lit("wait_states", states(), 32'h0000019);
        end

        for (int n = 0; n < 400; n++) begin
            hist.delete();
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else                           op = ops[$urandom_range(0, 8)];
            run_instr(op, 1'b1, 1'b1);
        end

        repeat (3) @(negedge clk);
        #5;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode latched in the instruction register and sequences the datapath through fetch, decode, execute, memory and write-back steps. Among its outputs it produces the 3-bit `ALUop` code consumed by the ALU control decoder, which expands `ALUop` and `funct` into the 4-bit ALU function. It sits between the instruction register and every datapath enable and mux select.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  6  IR[31:26]; sampled only in DECODE
- `mem_ready`  in  1  memory handshake (used only with `MC_MEM_WAIT_EN`)
- `PCWrite`, `PCWriteCond`, `BranchNe`  out  1 each  unconditional PC write; conditional PC write; branch on not-equal
- `IorD`, `MemRead`, `MemWrite`, `IRWrite`  out  1 each  memory address select (0=PC, 1=ALUOut) and memory/IR strobes
- `MemtoReg`, `RegDst`, `RegWrite`  out  1 each  register-file write-back controls
- `ALUSrcA`  out  1  0=PC, 1=A
- `ALUSrcB`  out  2  00=B, 01=4, 10=ext(imm), 11=ext(imm)<<2
- `ExtOp`  out  1  0=sign-extend, 1=zero-extend
- `PCSource`  out  2  00=ALU result, 01=ALUOut, 10=jump target
- `ALUop`  out  3  000 add, 001 sub, 010 R-type/funct, 011 or, 100 and
- `illegal_op`  out  1  one-cycle pulse on an unknown opcode
- `state`  out  4  current state, for debug

## Operation
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, andi=001100, ori=001101, j=000010.
- States 0–11: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BRANCH, JUMP, IEXEC, IWB.
- FETCH: MemRead, IRWrite, PCWrite, ALUSrcA=0, ALUSrcB=01, ALUop=000, PCSource=00. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=000, which computes the branch target into ALUOut. Dispatch on opcode:
  - lw or sw → MEMADR
  - R → REXEC
  - beq or bne → BRANCH
  - j → JUMP
  - addi, andi or ori → IEXEC
  - any other opcode → FETCH, with `illegal_op`=1 for that cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=000. lw → MEMRD; sw → MEMWR.
- MEMRD: MemRead, IorD=1 → MEMWB.
- MEMWB: RegWrite, MemtoReg=1, RegDst=0 → FETCH.
- MEMWR: MemWrite, IorD=1 → FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUop=010 → RWB.
- RWB: RegWrite, RegDst=1, MemtoReg=0 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=001, PCWriteCond, PCSource=01, BranchNe=(opcode==bne) → FETCH.
- JUMP: PCWrite, PCSource=10 → FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10.
  - addi: ALUop=000, ExtOp=0.
  - andi: ALUop=100, ExtOp=1.
  - ori: ALUop=011, ExtOp=1.
  - Next state is IWB.
- IWB: RegWrite, RegDst=0, MemtoReg=0, with ALUop and ExtOp held at their IEXEC values → FETCH.
- Every output not listed for a state is 0.

## Timing
- Outputs are Moore: decoded only from the `state` register and the registered opcode, with no combinational path from `opcode` (except the DECODE dispatch).
- The opcode is captured into an internal register at the DECODE→next transition. It is reused in BRANCH and IEXEC/IWB.
- Cycles per instruction with no wait states: lw 5; sw, R, addi/andi/ori 4; beq, bne, j 3.
- Reset:
  - `rst` high forces `state`=FETCH asynchronously.
  - While `rst` is high, PCWrite, PCWriteCond, IRWrite, MemWrite and RegWrite are forced to 0 and `illegal_op`=0.
  - All other outputs show their FETCH values.
  - After deassertion, the first rising edge completes a normal FETCH.
- Reset mid-instruction aborts the instruction immediately. No partial write occurs after the `rst` edge.

## Configuration
- `MC_MEM_WAIT_EN` defined:
  - FETCH, MEMRD and MEMWR hold their state and outputs until `mem_ready`=1, then advance on that edge.
  - PCWrite in FETCH is asserted only in the cycle where `mem_ready`=1, so the PC increments exactly once.
- `MC_MEM_WAIT_EN` undefined: memory is assumed single-cycle, `mem_ready` is ignored, and every state lasts one cycle.

## Structure
- Package `mc_pkg`:
  - state enum (4-bit)
  - opcode localparams
  - ALUop localparams
  - ALUSrcB and PCSource encodings
- One sub-module, `mc_output_decode`: purely combinational state+opcode → control word.
- Top level holds the state register, opcode register and next-state logic.

## Test plan
- Reset, then lw (100011): the state sequence is 0,1,2,3,4,0. MemRead=1 in FETCH and MEMRD; RegWrite=1 only in MEMWB with MemtoReg=1.
- R-type (000000): REXEC shows ALUop=010; RWB shows RegWrite=1, RegDst=1. The instruction takes 4 cycles.
- bne (000101): BRANCH shows ALUop=001, PCWriteCond=1, BranchNe=1, PCSource=01. The instruction returns to FETCH after 3 cycles.
- ori (001101) then andi (001100): IEXEC shows ALUop=011 with ExtOp=1, then ALUop=100 with ExtOp=1. IWB shows RegWrite=1.
- Opcode 111111: `illegal_op` pulses for 1 cycle in DECODE and the next state is FETCH. Assert `rst` in MEMWR: MemWrite drops within the same cycle and the state becomes FETCH.
- With `MC_MEM_WAIT_EN` and `mem_ready` held low for 3 cycles in FETCH: the state stays 0 and PCWrite=0 throughout. PCWrite=1 for exactly one cycle when `mem_ready` rises.
